// File: rtl/exc_sequencer.sv
// exc_sequencer
//   Exception/interrupt sequencer for the LEGv8 core. Arbitrates external
//   interrupt lines against illegal-opcode faults, records the return PC,
//   cause and source id, redirects fetch to the handler vector, masks
//   nesting while in the handler, and sequences the ERET return.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   irq_req        level interrupt requests, held until acked
//   not_an_instr   decoder flag: current instruction is illegal
//   eret           decoder flag: current instruction is ERET
//   pc             PC of the instruction in execute
//   flush          kill current instruction's reg/mem writes (combinational)
//   redirect_valid 1-cycle pulse: load redirect_pc into the PC
//   redirect_pc    redirect target, 0 when redirect_valid=0
//   irq_ack        one-hot 1-cycle ack to the serviced source
//   elr            saved return PC
//   esr            cause: 0001 IRQ, 0010 illegal, 0000 none
//   irq_id         index of the serviced IRQ (0 when cause is not an IRQ)
//   in_handler     high while in HANDLER
//   double_fault   high while in LOCK
module exc_sequencer #(
  parameter int unsigned NIRQ     = 4,
  parameter logic [63:0] VEC_BASE = 64'h0000_00D8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_req,
  input  logic            not_an_instr,
  input  logic            eret,
  input  logic [63:0]     pc,
  output logic            flush,
  output logic            redirect_valid,
  output logic [63:0]     redirect_pc,
  output logic [NIRQ-1:0] irq_ack,
  output logic [63:0]     elr,
  output logic [3:0]      esr,
  output logic [2:0]      irq_id,
  output logic            in_handler,
  output logic            double_fault
);

  typedef enum logic [2:0] {
    S_RUN,
    S_ENTER,
    S_HANDLER,
    S_RETURN,
    S_LOCK
  } state_t;

  localparam logic [3:0] ESR_NONE = 4'b0000;
  localparam logic [3:0] ESR_IRQ  = 4'b0001;
  localparam logic [3:0] ESR_ILL  = 4'b0010;

  state_t          state, state_d;
  logic [63:0]     elr_q, elr_d;
  logic [3:0]      esr_q, esr_d;
  logic [2:0]      id_q, id_d;

  logic            flush_c;
  logic            rv_c;
  logic [63:0]     rpc_c;
  logic [NIRQ-1:0] ack_c;
  logic            inh_c;
  logic            df_c;

  logic [2:0]      win;
  logic            win_found;

  // Lowest-index pending request wins.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (irq_req[i] && !win_found) begin
        win       = 3'(i);
        win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RUN;
      elr_q <= '0;
      esr_q <= ESR_NONE;
      id_q  <= '0;
    end else begin
      state <= state_d;
      elr_q <= elr_d;
      esr_q <= esr_d;
      id_q  <= id_d;
    end
  end

  always_comb begin
    state_d = state;
    elr_d   = elr_q;
    esr_d   = esr_q;
    id_d    = id_q;
    flush_c = 1'b0;
    rv_c    = 1'b0;
    rpc_c   = '0;
    ack_c   = '0;
    inh_c   = 1'b0;
    df_c    = 1'b0;

    case (state)
      S_RUN: begin
        // ERET outside a handler is treated as an illegal instruction.
        if (not_an_instr || eret) begin
          flush_c = 1'b1;
          elr_d   = pc;
          esr_d   = ESR_ILL;
          id_d    = '0;
          state_d = S_ENTER;
        end else if (win_found) begin
          flush_c = 1'b1;
          elr_d   = pc;
          esr_d   = ESR_IRQ;
          id_d    = win;
          state_d = S_ENTER;
        end
      end
      S_ENTER: begin
        rv_c  = 1'b1;
        rpc_c = VEC_BASE;
        if (esr_q == ESR_IRQ) begin
          for (int unsigned i = 0; i < NIRQ; i++) begin
            ack_c[i] = (id_q == 3'(i));
          end
        end
        state_d = S_HANDLER;
      end
      S_HANDLER: begin
        inh_c = 1'b1;
        if (not_an_instr) begin
          flush_c = 1'b1;
          state_d = S_LOCK;
        end else if (eret) begin
          state_d = S_RETURN;
        end
      end
      S_RETURN: begin
        rv_c    = 1'b1;
        rpc_c   = elr_q;
        esr_d   = ESR_NONE;
        id_d    = '0;
        state_d = S_RUN;
      end
      S_LOCK: begin
        df_c    = 1'b1;
        flush_c = 1'b1;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Outputs are forced low while reset is asserted, whatever the state.
  assign flush          = ~reset & flush_c;
  assign redirect_valid = ~reset & rv_c;
  assign redirect_pc    = reset ? '0 : rpc_c;
  assign irq_ack        = reset ? '0 : ack_c;
  assign elr            = reset ? '0 : elr_q;
  assign esr            = reset ? '0 : esr_q;
  assign irq_id         = reset ? '0 : id_q;
  assign in_handler     = ~reset & inh_c;
  assign double_fault   = ~reset & df_c;

endmodule

// File: tb/tb_exc_sequencer.sv
module tb_exc_sequencer;

  logic        clk;
  logic        reset;
  logic [3:0]  irq_req;
  logic        not_an_instr;
  logic        eret;
  logic [63:0] pc;
  logic        flush;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [3:0]  irq_ack;
  logic [63:0] elr;
  logic [3:0]  esr;
  logic [2:0]  irq_id;
  logic        in_handler;
  logic        double_fault;

  exc_sequencer #(
    .NIRQ    (4),
    .VEC_BASE(64'h0000_00D8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .irq_req       (irq_req),
    .not_an_instr  (not_an_instr),
    .eret          (eret),
    .pc            (pc),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .irq_ack       (irq_ack),
    .elr           (elr),
    .esr           (esr),
    .irq_id        (irq_id),
    .in_handler    (in_handler),
    .double_fault  (double_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        flush;
    logic        rv;
    logic [63:0] rpc;
    logic [3:0]  ack;
    logic [63:0] elr;
    logic [3:0]  esr;
    logic [2:0]  id;
    logic        inh;
    logic        df;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare each cycle's outputs against the expectation queued for it.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".flush"}, 64'(flush), 64'(e.flush));
      check({e.tag, ".rv"},    64'(redirect_valid), 64'(e.rv));
      check({e.tag, ".rpc"},   redirect_pc, e.rpc);
      check({e.tag, ".ack"},   64'(irq_ack), 64'(e.ack));
      check({e.tag, ".elr"},   elr, e.elr);
      check({e.tag, ".esr"},   64'(esr), 64'(e.esr));
      check({e.tag, ".id"},    64'(irq_id), 64'(e.id));
      check({e.tag, ".inh"},   64'(in_handler), 64'(e.inh));
      check({e.tag, ".df"},    64'(double_fault), 64'(e.df));
    end
  end

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(input string tag, input logic rst, input logic [3:0] irq,
                      input logic nai, input logic er, input logic [63:0] pcv,
                      input logic x_fl, input logic x_rv, input logic [63:0] x_rpc,
                      input logic [3:0] x_ack, input logic [63:0] x_elr,
                      input logic [3:0] x_esr, input logic [2:0] x_id,
                      input logic x_inh, input logic x_df);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst;
    irq_req      = irq;
    not_an_instr = nai;
    eret         = er;
    pc           = pcv;
    e.tag = tag; e.flush = x_fl; e.rv = x_rv; e.rpc = x_rpc; e.ack = x_ack;
    e.elr = x_elr; e.esr = x_esr; e.id = x_id; e.inh = x_inh; e.df = x_df;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b1; irq_req = '0; not_an_instr = 1'b0; eret = 1'b0; pc = '0;

    //     tag       rst irq     nai er pc       fl rv rpc      ack     elr      esr     id inh df
    step("rst0",     1, 4'b0000, 0, 0, 64'h0,   0, 0, 64'h0,  4'b0000, 64'h0,  4'b0000, 0, 0, 0);
    step("rst1",     1, 4'b1111, 1, 1, 64'h44,  0, 0, 64'h0,  4'b0000, 64'h0,  4'b0000, 0, 0, 0);
    step("idle",     0, 4'b0000, 0, 0, 64'h3C,  0, 0, 64'h0,  4'b0000, 64'h0,  4'b0000, 0, 0, 0);

    // IRQ2 taken at pc=0x40
    step("t1_run",   0, 4'b0100, 0, 0, 64'h40,  1, 0, 64'h0,  4'b0000, 64'h0,  4'b0000, 0, 0, 0);
    step("t1_ent",   0, 4'b0100, 0, 0, 64'h44,  0, 1, 64'hD8, 4'b0100, 64'h40, 4'b0001, 2, 0, 0);
    step("t1_hnd",   0, 4'b0000, 0, 0, 64'hD8,  0, 0, 64'h0,  4'b0000, 64'h40, 4'b0001, 2, 1, 0);
    step("t1_eret",  0, 4'b0000, 0, 1, 64'hDC,  0, 0, 64'h0,  4'b0000, 64'h40, 4'b0001, 2, 1, 0);
    step("t1_ret",   0, 4'b0000, 0, 0, 64'hE0,  0, 1, 64'h40, 4'b0000, 64'h40, 4'b0001, 2, 0, 0);
    step("t1_run2",  0, 4'b0000, 0, 0, 64'h40,  0, 0, 64'h0,  4'b0000, 64'h40, 4'b0000, 0, 0, 0);

    // Illegal instruction beats simultaneous IRQs
    step("t2_run",   0, 4'b0011, 1, 0, 64'h80,  1, 0, 64'h0,  4'b0000, 64'h40, 4'b0000, 0, 0, 0);
    step("t2_ent",   0, 4'b0011, 0, 0, 64'h84,  0, 1, 64'hD8, 4'b0000, 64'h80, 4'b0010, 0, 0, 0);

    // All IRQs held in the handler are masked
    for (int i = 0; i < 10; i++)
      step("t3_mask",0, 4'b1111, 0, 0, 64'hD8 + 64'(4*i),
                                                0, 0, 64'h0,  4'b0000, 64'h80, 4'b0010, 0, 1, 0);
    step("t3_eret",  0, 4'b1111, 0, 1, 64'h100, 0, 0, 64'h0,  4'b0000, 64'h80, 4'b0010, 0, 1, 0);
    step("t3_ret",   0, 4'b1111, 0, 0, 64'h104, 0, 1, 64'h80, 4'b0000, 64'h80, 4'b0010, 0, 0, 0);
    step("t3_run",   0, 4'b1111, 0, 0, 64'h80,  1, 0, 64'h0,  4'b0000, 64'h80, 4'b0000, 0, 0, 0);
    step("t3_ent",   0, 4'b1111, 0, 0, 64'h84,  0, 1, 64'hD8, 4'b0001, 64'h80, 4'b0001, 0, 0, 0);
    step("t3_hnd",   0, 4'b1110, 0, 0, 64'hD8,  0, 0, 64'h0,  4'b0000, 64'h80, 4'b0001, 0, 1, 0);

    // Double fault locks until reset
    step("t4_dflt",  0, 4'b0000, 1, 0, 64'hDC,  1, 0, 64'h0,  4'b0000, 64'h80, 4'b0001, 0, 1, 0);
    step("t4_lock0", 0, 4'b0000, 0, 1, 64'hE0,  1, 0, 64'h0,  4'b0000, 64'h80, 4'b0001, 0, 0, 1);
    step("t4_lock1", 0, 4'b1111, 0, 0, 64'hE4,  1, 0, 64'h0,  4'b0000, 64'h80, 4'b0001, 0, 0, 1);
    step("t4_lock2", 0, 4'b0000, 1, 0, 64'hE8,  1, 0, 64'h0,  4'b0000, 64'h80, 4'b0001, 0, 0, 1);
    step("t4_rst",   1, 4'b0000, 0, 0, 64'h0,   0, 0, 64'h0,  4'b0000, 64'h0,  4'b0000, 0, 0, 0);
    step("t4_idle",  0, 4'b0000, 0, 0, 64'h0,   0, 0, 64'h0,  4'b0000, 64'h0,  4'b0000, 0, 0, 0);

    // ERET in RUN is illegal
    step("t5_run",   0, 4'b0000, 0, 1, 64'h10,  1, 0, 64'h0,  4'b0000, 64'h0,  4'b0000, 0, 0, 0);
    step("t5_ent",   0, 4'b0000, 0, 0, 64'h14,  0, 1, 64'hD8, 4'b0000, 64'h10, 4'b0010, 0, 0, 0);
    step("t5_hnd",   0, 4'b0000, 0, 0, 64'hD8,  0, 0, 64'h0,  4'b0000, 64'h10, 4'b0010, 0, 1, 0);

    // Reset in ENTER
    step("t6_rst",   1, 4'b0000, 0, 0, 64'h0,   0, 0, 64'h0,  4'b0000, 64'h0,  4'b0000, 0, 0, 0);
    step("t6_run",   0, 4'b1000, 0, 0, 64'h30,  1, 0, 64'h0,  4'b0000, 64'h0,  4'b0000, 0, 0, 0);
    step("t6_entrs", 1, 4'b1000, 0, 0, 64'h34,  0, 0, 64'h0,  4'b0000, 64'h0,  4'b0000, 0, 0, 0);
    step("t6_after", 0, 4'b0000, 0, 0, 64'h30,  0, 0, 64'h0,  4'b0000, 64'h0,  4'b0000, 0, 0, 0);

    // Reset in RETURN
    step("t6b_run",  0, 4'b0000, 1, 0, 64'h50,  1, 0, 64'h0,  4'b0000, 64'h0,  4'b0000, 0, 0, 0);
    step("t6b_ent",  0, 4'b0000, 0, 0, 64'h54,  0, 1, 64'hD8, 4'b0000, 64'h50, 4'b0010, 0, 0, 0);
    step("t6b_eret", 0, 4'b0000, 0, 1, 64'hD8,  0, 0, 64'h0,  4'b0000, 64'h50, 4'b0010, 0, 1, 0);
    step("t6b_retr", 1, 4'b0000, 0, 0, 64'hDC,  0, 0, 64'h0,  4'b0000, 64'h0,  4'b0000, 0, 0, 0);
    step("t6b_aft",  0, 4'b0000, 0, 0, 64'h50,  0, 0, 64'h0,  4'b0000, 64'h0,  4'b0000, 0, 0, 0);

    // Highest-index line alone, full 64-bit ELR copy
    step("t7_run",   0, 4'b1000, 0, 0, 64'hFEDC_BA98_7654_3210,
                                                1, 0, 64'h0,  4'b0000, 64'h0,  4'b0000, 0, 0, 0);
    step("t7_ent",   0, 4'b1000, 0, 0, 64'h60,  0, 1, 64'hD8, 4'b1000,
                                                   64'hFEDC_BA98_7654_3210, 4'b0001, 3, 0, 0);
    step("t7_hnd",   0, 4'b0000, 0, 1, 64'hD8,  0, 0, 64'h0,  4'b0000,
                                                   64'hFEDC_BA98_7654_3210, 4'b0001, 3, 1, 0);
    step("t7_ret",   0, 4'b0000, 0, 0, 64'hDC,  0, 1, 64'hFEDC_BA98_7654_3210, 4'b0000,
                                                   64'hFEDC_BA98_7654_3210, 4'b0001, 3, 0, 0);

    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
